alu_mseq: RTL
=============

# alu_mseq

Parametrised, handshaked successor to the core's combinational ALU. It executes the RV base integer ops in one cycle and the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively. It sits in the execute stage between operand read and writeback. Input is a valid/ready request and output is a valid/ready response, so the pipeline stalls on long ops.

## Interface
- XLEN, 32: datapath width; must be a power of two, ≥ 8.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of any op in flight or held.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
- in1, in2  in  XLEN  operands.
- op  in  4  base op: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and; others produce result 0.
- funct3  in  3  M op select, used only when funct7 == 0000001: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- funct7  in  7  0000001 selects the M op; any other value selects op.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid && out_ready at a clk edge.
- result  out  XLEN  registered result.
- negative  out  1  result[XLEN-1], registered with result.
- zero  out  1  result == 0, registered with result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- in_ready = !flush && (IDLE || (DONE && out_ready)). out_valid = DONE.
- Operands, op and mode are latched on accept. Inputs are ignored at all other times.
- Base op accepted: go directly to DONE and register result.
  - Shift amount is in2[log2(XLEN)-1:0].
  - slt/sltu produce 0 or 1, zero-extended.
- M multiply accepted: enter MUL with an iteration counter of XLEN.
  - One shift-add step per cycle on a 2·XLEN accumulator of operand magnitudes.
  - Sign is corrected on the final step.
  - mul returns the low XLEN bits. mulh/mulhsu/mulhu return the high XLEN bits, with both operands signed, in1 signed/in2 unsigned, and both unsigned respectively.
- M divide accepted: enter DIV with a counter of XLEN.
  - One restoring step per cycle on magnitudes.
  - Quotient sign = sign(in1) XOR sign(in2). Remainder sign = sign(in1).
- Divide fast paths go straight to DONE (1 cycle):
  - in2 == 0: div/divu give all ones; rem/remu give in1.
  - Signed overflow (in1 = 100…0, in2 = all ones): div gives in1; rem gives 0.
- DONE holds result, negative and zero stable until out_ready.
  - On pop: go to IDLE, or take the next request if in_valid is high in the same cycle.
- flush takes priority over everything except reset.
  - Next state is IDLE, out_valid drops and no request is accepted that cycle.
  - result is unchanged.
- Reset (async, any state): state = IDLE, counter = 0, result = 0, negative = 0, zero = 0, out_valid = 0.
  - in_ready = 1 after reset release (flush low).
- All arithmetic is modulo 2^XLEN. Counter width is log2(XLEN)+1.

## Timing
- Accept at edge E0.
- Base op or divide fast path: out_valid high after E0 (latency 1).
- MUL/DIV: iteration steps at E1..E_XLEN. out_valid high after E_XLEN (latency XLEN+1, fixed, independent of data).
- Back-to-back base ops with out_ready held high: one accept per cycle (throughput 1).
- Under backpressure (out_ready low): DONE persists and in_ready stays low.
- All outputs are registered. There is no combinational path from in1/in2/op to result.

## Test plan
- Reset, then add: in1 = 0x0000000F, in2 = 0x000000F0, op 0000 → result 0x000000FF, negative 0, zero 0, out_valid one cycle after accept. Hold out_ready low 3 cycles → outputs stable, in_ready 0.
- Base sweep with out_ready = 1, one op per cycle:
  - sra 0xFFFFFFFF by 1 → 0xFFFFFFFF, negative 1.
  - slt 0xFF vs 0x7F → 0.
  - sub 0 − 1 → 0xFFFFFFFF.
  - add 0xFFFFFFFF + 1 → 0, zero 1.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF: mul → 0x00000001, mulh → 0x00000000, mulhu → 0xFFFFFFFE. out_valid exactly 33 cycles after accept.
- Divide:
  - div −7/2 → 0xFFFFFFFD, rem → 0xFFFFFFFF (33 cycles each).
  - divu 7/0 → 0xFFFFFFFF and rem 5/0 → 5, each in 1 cycle.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000, rem → 0, each in 1 cycle.
- Abort during divide:
  - flush 10 cycles into a divide → out_valid never rises, in_ready 1 on the next cycle, a following add completes correctly.
  - in_valid asserted with flush → not accepted.
- Async reset mid-multiply: assert rst_n low between edges → out_valid and result are 0 immediately. After release, mulhu 2 × 3 → 0.

Source files
------------

// File: rtl/alu_mseq.sv
// alu_mseq: RV base integer ALU (single cycle) plus iterative M-extension
// multiply/divide, with valid/ready handshakes on request and response.
module alu_mseq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [3:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            negative,
  output logic            zero
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [1:0]        mop;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc, mul_nxt, div_nxt, prod;
  logic [XLEN:0]     msum, dtrial;

  logic            accept, is_m, is_div, dsigned, sgn1, sgn2, divz, ovf, fast, last, res_we;
  logic [XLEN-1:0] fast_val, res_nxt, q_mag, r_mag;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] base_op(input logic [3:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SW-1:0] sh;
    sa = a;
    sb = b;
    sh = b[SW-1:0];
    case (o)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << sh;
      4'b0011: return {{(XLEN-1){1'b0}}, sa < sb};
      4'b0100: return {{(XLEN-1){1'b0}}, a < b};
      4'b0101: return a ^ b;
      4'b0110: return a >> sh;
      4'b0111: return $unsigned(sa >>> sh);
      4'b1000: return a | b;
      4'b1001: return a & b;
      default: return '0;
    endcase
  endfunction

  // Request decode: operand signedness and divide fast paths
  always_comb begin
    is_m    = (funct7 == 7'b0000001);
    is_div  = funct3[2];
    dsigned = !funct3[0];
    sgn1    = in1[XLEN-1] && (is_div ? dsigned : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
    sgn2    = in2[XLEN-1] && (is_div ? dsigned : (funct3[1:0] == 2'b01));
    divz    = (in2 == '0);
    ovf     = dsigned && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    fast    = is_div && (divz || ovf);
    if (divz) fast_val = funct3[1] ? in1 : '1;
    else      fast_val = funct3[1] ? '0 : in1;
  end

  assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign last      = (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (accept) begin
      if (is_m && !fast) state_nxt = is_div ? DIV : MUL;
      else               state_nxt = DONE;
    end else begin
      case (state)
        MUL, DIV: if (last) state_nxt = DONE;
        DONE:     if (out_ready) state_nxt = IDLE;
        default:  ;
      endcase
    end
  end

  // Iteration step: acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_nxt = {msum, acc[XLEN-1:1]};
    dtrial  = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand};
    if (dtrial[XLEN]) div_nxt = {acc[2*XLEN-2:0], 1'b0};
    else              div_nxt = {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod    = neg_q ? -mul_nxt : mul_nxt;
    q_mag   = div_nxt[XLEN-1:0];
    r_mag   = div_nxt[2*XLEN-1:XLEN];
    res_we  = 1'b0;
    res_nxt = result;
    if (accept && !(is_m && !fast)) begin
      res_we  = 1'b1;
      res_nxt = is_m ? fast_val : base_op(op, in1, in2);
    end else if (!flush && last && state == MUL) begin
      res_we  = 1'b1;
      res_nxt = (mop == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (!flush && last && state == DIV) begin
      res_we  = 1'b1;
      res_nxt = mop[1] ? mag(r_mag, neg_r) : mag(q_mag, neg_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      result   <= '0;
      negative <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && is_m && !fast)
        cnt <= CW'(XLEN);
      else if ((state == MUL || state == DIV) && cnt != '0)
        cnt <= cnt - CW'(1);
      if (res_we) begin
        result   <= res_nxt;
        negative <= res_nxt[XLEN-1];
        zero     <= (res_nxt == '0);
      end
    end
  end

  // Operand magnitudes latched on accept; datapath carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mop   <= funct3[1:0];
      neg_q <= sgn1 ^ sgn2;
      neg_r <= sgn1;
      if (is_div) begin
        mcand <= mag(in2, sgn2);
        acc   <= {{XLEN{1'b0}}, mag(in1, sgn1)};
      end else begin
        mcand <= mag(in1, sgn1);
        acc   <= {{XLEN{1'b0}}, mag(in2, sgn2)};
      end
    end else if (state == MUL) begin
      acc <= mul_nxt;
    end else if (state == DIV) begin
      acc <= div_nxt;
    end
  end

endmodule
